// File: rtl/cache_miss_handler.sv
// cache_miss_handler: sequential front end for a combinational direct-mapped
// cache lookup. Serves one CPU request at a time: read hits return the cached
// word, read misses fetch from memory and fill the line, writes go through to
// memory and allocate the line.
// Optional feature: define MISS_TIMEOUT_EN to bound the memory-read wait to
// TIMEOUT_CYC cycles; on expiry the request completes with cpu_rsp_err=1,
// rdata=0 and no fill.
//
// Handshakes: a request transfers on a rising edge where valid and ready are
// both high; the requester holds valid and its payload stable until then, and
// the receiver may drop ready at any time. cpu_req_ready is high only in IDLE,
// mem_req_valid only in MEM_REQ. Responses (cpu_rsp_valid, mem_rsp_valid) are
// single-cycle pulses with no back-pressure.
module cache_miss_handler #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int INDEX_W     = 15,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cpu_req_valid,
   output logic                        cpu_req_ready,
   input  logic [ADDR_W-1:0]           cpu_addr,
   input  logic                        cpu_rw,
   input  logic [DATA_W-1:0]           cpu_wdata,
   output logic                        cpu_rsp_valid,
   output logic [DATA_W-1:0]           cpu_rdata,
   output logic                        cpu_rsp_miss,
   output logic                        cpu_rsp_err,
   output logic [ADDR_W-1:0]           cache_addr,
   output logic                        cache_r_w,
   input  logic                        cache_h_m,
   input  logic [DATA_W-1:0]           cache_data,
   output logic                        fill_we,
   output logic [INDEX_W-1:0]          fill_index,
   output logic [ADDR_W-INDEX_W-3:0]   fill_tag,
   output logic [DATA_W-1:0]           fill_data,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_we,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic                        mem_rsp_valid,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [2:0]                  state_dbg
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      MEM_REQ  = 3'd2,
      MEM_WAIT = 3'd3,
      FILL     = 3'd4,
      RESP     = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [ADDR_W-1:0]   addr_q;
   logic                rw_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   data_q;       // word headed for the fill and the response
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_miss_q;
   logic                read_hit;
   logic                timeout_hit;

   assign read_hit = !rw_q && !cache_h_m;

`ifdef MISS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0]    wait_cnt;
   logic                rsp_err_q;

   // Count MEM_WAIT cycles without a response; held at zero in every other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (state != MEM_WAIT)
         wait_cnt <= '0;
      else if (!mem_rsp_valid)
         wait_cnt <= wait_cnt + 1'b1;
   end

   // The last silent wait cycle is the TIMEOUT_CYC-th one; a response in that cycle still wins.
   assign timeout_hit = (state == MEM_WAIT) && !mem_rsp_valid &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Error flag belongs to the response fields: rewritten only on the way into RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rsp_err_q <= 1'b0;
      else if ((state == LOOKUP && read_hit) || state == FILL)
         rsp_err_q <= 1'b0;
      else if (timeout_hit)
         rsp_err_q <= 1'b1;
   end

   assign cpu_rsp_err = rsp_err_q;
`else
   assign timeout_hit = 1'b0;
   assign cpu_rsp_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (cpu_req_valid) state_nxt = LOOKUP;
         LOOKUP:   state_nxt = read_hit ? RESP : MEM_REQ;
         MEM_REQ:  if (mem_req_ready) state_nxt = rw_q ? FILL : MEM_WAIT;
         MEM_WAIT: begin
            if (mem_rsp_valid)
               state_nxt = FILL;
            else if (timeout_hit)
               state_nxt = RESP;
         end
         FILL:     state_nxt = RESP;
         RESP:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Control outputs are pure functions of the state.
   always_comb begin
      cpu_req_ready = 1'b0;
      cpu_rsp_valid = 1'b0;
      mem_req_valid = 1'b0;
      fill_we       = 1'b0;
      case (state)
         IDLE:    cpu_req_ready = 1'b1;
         MEM_REQ: mem_req_valid = 1'b1;
         FILL:    fill_we       = 1'b1;
         RESP:    cpu_rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request capture, fill data and response fields; response fields change only entering RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         rw_q        <= 1'b0;
         wdata_q     <= '0;
         data_q      <= '0;
         rsp_rdata_q <= '0;
         rsp_miss_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req_valid) begin
                  addr_q  <= cpu_addr;
                  rw_q    <= cpu_rw;
                  wdata_q <= cpu_wdata;
               end
            end
            LOOKUP: begin
               if (read_hit) begin
                  rsp_rdata_q <= cache_data;
                  rsp_miss_q  <= 1'b0;
               end
            end
            MEM_REQ: begin
               if (mem_req_ready && rw_q)
                  data_q <= wdata_q;
            end
            MEM_WAIT: begin
               if (mem_rsp_valid) begin
                  data_q <= mem_rdata;
               end else if (timeout_hit) begin
                  rsp_rdata_q <= '0;
                  rsp_miss_q  <= 1'b1;
               end
            end
            FILL: begin
               rsp_rdata_q <= data_q;
               rsp_miss_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cache_addr   = addr_q;
   assign cache_r_w    = rw_q;
   assign mem_addr     = addr_q;
   assign mem_we       = rw_q;
   assign mem_wdata    = wdata_q;
   assign fill_index   = addr_q[INDEX_W+1:2];
   assign fill_tag     = addr_q[ADDR_W-1:INDEX_W+2];
   assign fill_data    = data_q;
   assign cpu_rdata    = rsp_rdata_q;
   assign cpu_rsp_miss = rsp_miss_q;
   assign state_dbg    = state;

endmodule

// File: tb/tb_cache_miss_handler.sv
// tb_cache_miss_handler: directed and randomized checks of cache_miss_handler.
// The bench plays the lookup block (tag/data arrays written by fill_we) and
// the memory, and predicts every response from a line/word-level model.
module tb_cache_miss_handler;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 15;
   localparam int TW = AW - IW - 2;
`ifdef MISS_TIMEOUT_EN
   localparam int TCYC = 8;
`else
   localparam int TCYC = 255;
`endif

   logic          clk;
   logic          rst;
   logic          cpu_req_valid;
   logic          cpu_req_ready;
   logic [AW-1:0] cpu_addr;
   logic          cpu_rw;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_rsp_valid;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rsp_miss;
   logic          cpu_rsp_err;
   logic [AW-1:0] cache_addr;
   logic          cache_r_w;
   logic          cache_h_m;
   logic [DW-1:0] cache_data;
   logic          fill_we;
   logic [IW-1:0] fill_index;
   logic [TW-1:0] fill_tag;
   logic [DW-1:0] fill_data;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic          mem_rsp_valid;
   logic [DW-1:0] mem_rdata;
   logic [2:0]    state_dbg;

   int checks   = 0;
   int failures = 0;

   cache_miss_handler #(
      .ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .TIMEOUT_CYC(TCYC)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
      .cpu_rsp_miss(cpu_rsp_miss), .cpu_rsp_err(cpu_rsp_err),
      .cache_addr(cache_addr), .cache_r_w(cache_r_w),
      .cache_h_m(cache_h_m), .cache_data(cache_data),
      .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- lookup block model (arrays) ----------------
   bit            c_valid [0:(1<<IW)-1];
   logic [TW-1:0] c_tag   [0:(1<<IW)-1];
   logic [DW-1:0] c_data  [0:(1<<IW)-1];
   logic          pre_we;
   logic [IW-1:0] pre_idx;
   logic [TW-1:0] pre_tag;
   logic [DW-1:0] pre_data;

   assign cache_h_m  = !(c_valid[cache_addr[IW+1:2]] &&
                         (c_tag[cache_addr[IW+1:2]] == cache_addr[AW-1:IW+2]));
   assign cache_data = c_data[cache_addr[IW+1:2]];

   // Array writes: fills from the DUT, or a one-cycle preload from the bench.
   always @(posedge clk) begin
      if (fill_we) begin
         c_valid[fill_index] <= 1'b1;
         c_tag[fill_index]   <= fill_tag;
         c_data[fill_index]  <= fill_data;
      end else if (pre_we) begin
         c_valid[pre_idx] <= 1'b1;
         c_tag[pre_idx]   <= pre_tag;
         c_data[pre_idx]  <= pre_data;
      end
   end

   // ---------------- memory and reference model ----------------
   logic [DW-1:0] mem_arr      [logic [29:0]];   // memory contents as seen by the responder
   logic [DW-1:0] ref_mem      [logic [29:0]];   // expected memory contents
   logic [DW-1:0] ref_line_data[int];            // expected cache lines by index
   logic [TW-1:0] ref_line_tag [int];
   logic [DW-1:0] last_rdata;

   function automatic logic [DW-1:0] init_word(input logic [29:0] w);
      return {w[13:0], 2'b10, w[15:0]} ^ 32'hA5C3_0F1E;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_state"},     64'(state_dbg),     64'(0));
      check({pfx, "_ready"},     64'(cpu_req_ready), 64'(1));
      check({pfx, "_rsp_valid"}, 64'(cpu_rsp_valid), 64'(0));
      check({pfx, "_rdata"},     64'(cpu_rdata),     64'(0));
      check({pfx, "_miss"},      64'(cpu_rsp_miss),  64'(0));
      check({pfx, "_err"},       64'(cpu_rsp_err),   64'(0));
      check({pfx, "_cache_addr"},64'(cache_addr),    64'(0));
      check({pfx, "_mem_valid"}, 64'(mem_req_valid), 64'(0));
      check({pfx, "_mem_addr"},  64'(mem_addr),      64'(0));
      check({pfx, "_fill_we"},   64'(fill_we),       64'(0));
      check({pfx, "_fill_idx"},  64'(fill_index),    64'(0));
      check({pfx, "_fill_data"}, 64'(fill_data),     64'(0));
   endtask

   // One CPU transaction: drives the request, plays memory, checks every observable step.
   // abort_at > 0 leaves the task at that cycle without completing or updating the model.
   task automatic do_req(input logic [AW-1:0] addr, input logic rw, input logic [DW-1:0] wdata,
                         input int rdy_dly, input int rsp_dly, input bit stray, input bit hold,
                         input int abort_at);
      int            idx;
      logic [TW-1:0] tg;
      logic [29:0]   w;
      bit            exp_hit, exp_err, exp_fill, done, acc, in_wait, aborted;
      logic [DW-1:0] exp_data, acc_data;
      int            exp_lat, cyc, req_cyc, wcnt, fills;

      idx = int'(addr[IW+1:2]);
      tg  = addr[AW-1:IW+2];
      w   = addr[31:2];
      exp_hit = !rw && ref_line_tag.exists(idx) && (ref_line_tag[idx] == tg);
      exp_err = 1'b0;
      if (rw) begin
         exp_data = wdata;
         exp_lat  = 4 + rdy_dly;
      end else if (exp_hit) begin
         exp_data = ref_line_data[idx];
         exp_lat  = 2;
      end else if (rsp_dly >= TCYC) begin
         exp_data = '0;
         exp_err  = 1'b1;
         exp_lat  = 3 + rdy_dly + TCYC;
      end else begin
         exp_data = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
         exp_lat  = 5 + rdy_dly + rsp_dly;
      end
      exp_fill = !exp_hit && !exp_err;

      @(negedge clk);
      check("ready_idle", 64'(cpu_req_ready), 64'(1));
      cpu_req_valid = 1'b1;
      cpu_addr      = addr;
      cpu_rw        = rw;
      cpu_wdata     = wdata;
      @(posedge clk);
      cyc = 0; req_cyc = 0; wcnt = 0; fills = 0;
      done = 0; acc = 0; in_wait = 0; aborted = 0; acc_data = '0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == abort_at) begin
            aborted = 1;
            break;
         end
         if (!hold) cpu_req_valid = 1'b0;
         mem_rsp_valid = 1'b0;
         mem_rdata     = '0;
         if (acc) begin
            if (rw) mem_arr[w] = acc_data;
            else begin
               in_wait = 1;
               wcnt    = 0;
            end
            acc = 0;
         end
         check("busy_ready", 64'(cpu_req_ready), 64'(0));
         if (mem_req_valid) begin
            req_cyc++;
            check("mem_addr", 64'(mem_addr), 64'(addr));
            check("mem_we",   64'(mem_we),   64'(rw));
            if (rw) check("mem_wdata", 64'(mem_wdata), 64'(wdata));
            mem_req_ready = (req_cyc > rdy_dly);
            if (mem_req_ready) begin
               acc      = 1;
               acc_data = mem_wdata;
               if (stray) begin
                  mem_rsp_valid = 1'b1;
                  mem_rdata     = 32'hBAD0_BAD0;
               end
            end
         end else begin
            mem_req_ready = 1'b0;
         end
         if (in_wait) begin
            if (wcnt == rsp_dly) begin
               mem_rsp_valid = 1'b1;
               mem_rdata     = mem_arr.exists(w) ? mem_arr[w] : init_word(w);
               in_wait       = 0;
            end
            wcnt++;
         end
         if (fill_we) begin
            fills++;
            check("fill_index", 64'(fill_index), 64'(addr[IW+1:2]));
            check("fill_tag",   64'(fill_tag),   64'(tg));
            check("fill_data",  64'(fill_data),  64'(exp_data));
         end
         if (cpu_rsp_valid) begin
            done = 1;
            check("rsp_rdata",   64'(cpu_rdata),    64'(exp_data));
            check("rsp_miss",    64'(cpu_rsp_miss), 64'(!exp_hit));
            check("rsp_err",     64'(cpu_rsp_err),  64'(exp_err));
            check("rsp_latency", 64'(cyc),          64'(exp_lat));
            check("fill_count",  64'(fills),        64'(exp_fill));
            check("mem_req_cycles", 64'(req_cyc),   64'(exp_hit ? 0 : rdy_dly + 1));
         end
      end
      if (aborted) return;
      if (!done) check("rsp_arrived", 64'(0), 64'(1));
      cpu_req_valid = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (exp_fill) begin
         ref_line_tag[idx]  = tg;
         ref_line_data[idx] = exp_data;
      end
      if (rw) ref_mem[w] = wdata;
      last_rdata = exp_data;
   endtask

   // Stray memory response while idle must change nothing.
   task automatic idle_stray(input string pfx);
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rdata     = $urandom;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         check({pfx, "_fill_we"},   64'(fill_we),       64'(0));
         check({pfx, "_rsp_valid"}, 64'(cpu_rsp_valid), 64'(0));
         check({pfx, "_ready"},     64'(cpu_req_ready), 64'(1));
         check({pfx, "_rdata_hold"},64'(cpu_rdata),     64'(last_rdata));
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [AW-1:0] a;
      rst = 1'b1;
      cpu_req_valid = 1'b0; cpu_addr = '0; cpu_rw = 1'b0; cpu_wdata = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      pre_we = 1'b0; pre_idx = '0; pre_tag = '0; pre_data = '0;
      last_rdata = '0;

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Preload index 0 tag 0 in the lookup arrays and the model.
      pre_we = 1'b1; pre_idx = '0; pre_tag = '0; pre_data = 32'hCAFE_BABE;
      @(negedge clk);
      pre_we = 1'b0;
      ref_line_tag[0]  = '0;
      ref_line_data[0] = 32'hCAFE_BABE;

      // Read hit.
      do_req(32'h0000_0000, 1'b0, '0, 0, 0, 0, 0, 0);

      // Read miss, memory answers a few cycles later.
      mem_arr[30'h0000_8001] = 32'h1234_5678;
      ref_mem[30'h0000_8001] = 32'h1234_5678;
      do_req(32'h0002_0004, 1'b0, '0, 0, 2, 0, 0, 0);
      // Same address again now hits the filled line.
      do_req(32'h0002_0004, 1'b0, '0, 0, 0, 0, 0, 0);

      // Write-through with memory stalling the request for 4 cycles.
      do_req(32'h0000_0008, 1'b1, 32'hABAD_DEED, 4, 0, 0, 0, 0);
      do_req(32'h0000_0008, 1'b0, '0, 0, 0, 0, 0, 0);

      // Reset while waiting for memory.
      do_req(32'h0004_0010, 1'b0, '0, 0, 1000, 0, 0, 4);
      check("pre_abort_state", 64'(state_dbg), 64'(3));
      #1 rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      rst = 1'b0;
      last_rdata = '0;
      idle_stray("post_abort");

      // Request held high through a miss, stray response on the accept cycle.
      do_req(32'h0006_0020, 1'b0, '0, 1, 1, 1, 1, 0);
      idle_stray("idle");
      do_req(32'h0006_0020, 1'b0, '0, 0, 0, 0, 0, 0);

      // Randomized traffic over a small set of lines and tags.
      for (int n = 0; n < 40; n++) begin
         a = '0;
         a[AW-1:IW+2] = TW'($urandom_range(0, 3));
         a[IW+1:2]    = IW'($urandom_range(0, 7));
         a[1:0]       = 2'($urandom_range(0, 3));
         do_req(a, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

`ifdef MISS_TIMEOUT_EN
      // Memory never answers: error response, no fill, late response ignored.
      do_req(32'h000A_0040, 1'b0, '0, 0, 1000, 0, 0, 0);
      idle_stray("late_rsp");
      do_req(32'h000A_0040, 1'b0, '0, 0, 0, 0, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
